multicycle_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 16-bit datapath top. Fetches 16-bit instructions and executes them through a FETCH/DECODE/EXEC/MEM/WB state machine with req/ack memory handshakes. Run/step control replaces the push-button clock, so the core runs on the board clock. Datapath width and PC width are generic. Instruction format stays 16-bit with an 8-entry register file; r0 is hardwired to 0.

---
 rtl/multicycle_core.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_core.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// Multi-cycle 16-bit-instruction core: FETCH/DECODE/EXEC/MEM/WB sequencing with
// req/ack memory handshakes, run/step control and an 8-entry register file (r0 = 0).
//
// state   | meaning
// IDLE    | waiting for run level or a new step pulse
// FETCH   | imem_req held until imem_ack, IR latched
// DECODE  | operand registers loaded from the register file
// EXEC    | ALU/address/branch; BEQ, NOP and HALT retire here
// MEM     | dmem_req held until dmem_ack; SW retires here
// WB      | register write, pc+1, retire
// HALTED  | parked until reset
module multicycle_core #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 9,
  parameter int RET_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              ovf,
  output logic              take_branch,
  output logic              retired,
  output logic [RET_W-1:0]  retire_count,
  output logic [DATA_W-1:0] wb_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t              state, state_n;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   regs [8];
  logic [DATA_W-1:0]   a_q, b_q, d_q, res_q, addr_q;
  logic [PC_W-1:0]     pc_r;
  logic                halted_r, ovf_r, tb_r, step_q;
  logic [RET_W-1:0]    ret_cnt;
  logic [DATA_W-1:0]   wb_r;

  logic [3:0]          op;
  logic [2:0]          rd, rs1, rs2;
  logic [DATA_W-1:0]   imm;
  logic [PC_W-1:0]     pc_imm, pc_inc;
  logic                is_nop, step_rise, retire;
  logic [DATA_W-1:0]   alu_res, sum_ab, dif_ab, sum_ai;
  logic                ovf_c;

  assign op      = ir[15:12];
  assign rd      = ir[11:9];
  assign rs1     = ir[8:6];
  assign rs2     = ir[5:3];
  assign imm     = {{(DATA_W-6){ir[5]}}, ir[5:0]};
  assign pc_imm  = {{(PC_W-6){ir[5]}}, ir[5:0]};
  assign pc_inc  = pc_r + PC_W'(1);
  assign is_nop  = (op >= 4'd9) && (op <= 4'd14);
  // step acts on its rising edge so a held step cannot chain instructions
  assign step_rise = step & ~step_q;

  assign sum_ab = a_q + b_q;
  assign dif_ab = a_q - b_q;
  assign sum_ai = a_q + imm;

  always_comb begin
    alu_res = sum_ab;
    ovf_c   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum_ab;
        ovf_c   = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum_ab[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = dif_ab;
        ovf_c   = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (dif_ab[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_ADDI: begin
        alu_res = sum_ai;
        ovf_c   = (a_q[DATA_W-1] == imm[DATA_W-1]) && (sum_ai[DATA_W-1] != a_q[DATA_W-1]);
      end
      default: alu_res = sum_ai;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    retire  = 1'b0;
    case (state)
      S_IDLE:   if (run || step_rise) state_n = S_FETCH;
      S_FETCH:  if (imem_ack) state_n = S_DECODE;
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        if (op == OP_LW || op == OP_SW) begin
          state_n = S_MEM;
        end else if (op == OP_HALT) begin
          state_n = S_HALTED;
          retire  = 1'b1;
        end else if (op == OP_BEQ || is_nop) begin
          state_n = run ? S_FETCH : S_IDLE;
          retire  = 1'b1;
        end else begin
          state_n = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op == OP_SW) begin
            state_n = run ? S_FETCH : S_IDLE;
            retire  = 1'b1;
          end else begin
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        state_n = run ? S_FETCH : S_IDLE;
        retire  = 1'b1;
      end
      S_HALTED: state_n = S_HALTED;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      res_q    <= '0;
      addr_q   <= '0;
      pc_r     <= '0;
      halted_r <= 1'b0;
      ovf_r    <= 1'b0;
      tb_r     <= 1'b0;
      step_q   <= 1'b0;
      ret_cnt  <= '0;
      wb_r     <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      step_q <= step;
      if (retire) ret_cnt <= ret_cnt + RET_W'(1);
      case (state)
        S_FETCH: if (imem_ack) ir <= imem_rdata;
        S_DECODE: begin
          a_q <= regs[rs1];
          b_q <= regs[rs2];
          d_q <= regs[rd];
        end
        S_EXEC: begin
          res_q  <= alu_res;
          addr_q <= sum_ai;
          if (op == OP_ADD || op == OP_SUB || op == OP_ADDI) ovf_r <= ovf_c;
          if (op == OP_BEQ) begin
            tb_r <= (d_q == a_q);
            pc_r <= (d_q == a_q) ? pc_inc + pc_imm : pc_inc;
          end
          if (is_nop) pc_r <= pc_inc;
          if (op == OP_HALT) halted_r <= 1'b1;
        end
        S_MEM: begin
          if (dmem_ack && op == OP_LW) res_q <= dmem_rdata;
          if (dmem_ack && op == OP_SW) pc_r <= pc_inc;
        end
        S_WB: begin
          if (rd != 3'd0) regs[rd] <= res_q;
          wb_r <= res_q;
          pc_r <= pc_inc;
        end
        default: ;
      endcase
    end
  end

  assign imem_req     = (state == S_FETCH);
  assign imem_addr    = pc_r;
  assign dmem_req     = (state == S_MEM);
  assign dmem_we      = (state == S_MEM) && (op == OP_SW);
  assign dmem_addr    = dmem_req ? addr_q : '0;
  assign dmem_wdata   = dmem_we ? d_q : '0;
  assign pc           = pc_r;
  assign halted       = halted_r;
  assign ovf          = ovf_r;
  assign take_branch  = tb_r;
  assign retired      = retire;
  assign retire_count = ret_cnt;
  assign wb_data      = wb_r;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small programs with zero-wait and delayed
// memories, hand-computed register/flag/latency expectations.
module tb_multicycle_core;
  localparam int DATA_W = 16;
  localparam int PC_W   = 9;
  localparam int RET_W  = 32;

  logic              clk = 1'b0;
  logic              reset, run, step;
  logic              imem_req, imem_ack;
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_rdata;
  logic              dmem_req, dmem_we, dmem_ack;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [PC_W-1:0]   pc;
  logic              halted, ovf, take_branch, retired;
  logic [RET_W-1:0]  retire_count;
  logic [DATA_W-1:0] wb_data;

  multicycle_core #(.DATA_W(DATA_W), .PC_W(PC_W), .RET_W(RET_W)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .halted(halted), .ovf(ovf), .take_branch(take_branch), .retired(retired),
    .retire_count(retire_count), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  logic [15:0]       imem [512];
  logic [DATA_W-1:0] dmem [16];
  int                dwait = 0;
  int                dcnt  = 0;
  int                cyc   = 0;

  assign imem_ack   = imem_req;
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt == dwait);
  assign dmem_rdata = dmem[dmem_addr[3:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
    else                       dcnt <= 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[3:0]] <= dmem_wdata;
  end

  // Retirement log (sampled one cycle after each retire) and dmem access tracking.
  logic [DATA_W-1:0] log_wb [$];
  logic              log_ovf [$];
  logic              log_tb [$];
  logic [PC_W-1:0]   log_pc [$];
  int                ret_cyc [$];
  int                acc_len [$];
  logic              pend = 1'b0;
  int                ret_pulses = 0;
  int                dlen = 0;
  int                n_unstable = 0;
  logic              p_req = 1'b0, p_we = 1'b0;
  logic [DATA_W-1:0] p_addr = '0, p_wdata = '0;

  always @(negedge clk) begin
    if (pend) begin
      log_wb.push_back(wb_data);
      log_ovf.push_back(ovf);
      log_tb.push_back(take_branch);
      log_pc.push_back(pc);
    end
    pend <= retired;
    if (retired) begin
      ret_cyc.push_back(cyc);
      ret_pulses <= ret_pulses + 1;
    end
    if (dmem_req && p_req &&
        (dmem_addr !== p_addr || dmem_we !== p_we || dmem_wdata !== p_wdata))
      n_unstable <= n_unstable + 1;
    if (dmem_req) begin
      if (dmem_ack) begin
        acc_len.push_back(dlen + 1);
        dlen <= 0;
      end else begin
        dlen <= dlen + 1;
      end
    end
    p_req   <= dmem_req;
    p_we    <= dmem_we;
    p_addr  <= dmem_addr;
    p_wdata <= dmem_wdata;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [5:0] lo);
    return {op, rd, rs1, lo};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 512; i++) imem[i] = 16'h0000;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, halted, 1'b1);
  endtask

  task automatic load_mem_prog();
    clear_imem();
    imem[0] = enc(4'd4, 3'd1, 3'd0, 6'h39);   // ADDI r1,r0,-7
    imem[1] = enc(4'd6, 3'd1, 3'd0, 6'd0);    // SW r1,0(r0)
    imem[2] = enc(4'd5, 3'd4, 3'd0, 6'd0);    // LW r4,0(r0)
    imem[3] = enc(4'd6, 3'd4, 3'd0, 6'd1);    // SW r4,1(r0)
    imem[4] = enc(4'd7, 3'd1, 3'd0, 6'd5);    // BEQ r1,r0,5 (not taken)
    imem[5] = enc(4'd15, 3'd0, 3'd0, 6'd0);   // HALT
  endtask

  initial begin
    int k, n, base, abase, p0;

    // ---- reset state ----
    clear_imem();
    hold_reset();
    check("rst_pc", pc, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_retire_count", retire_count, 0);
    check("rst_halted", halted, 0);
    check("rst_wb_data", wb_data, 0);

    // ---- ADDI/ADDI/ADD/HALT, zero-wait, latency 4+4+4+3 ----
    imem[0] = enc(4'd4, 3'd1, 3'd0, 6'd5);
    imem[1] = enc(4'd4, 3'd2, 3'd0, 6'h3D);
    imem[2] = enc(4'd0, 3'd3, 3'd1, {3'd2, 3'd0});
    imem[3] = enc(4'd15, 3'd0, 3'd0, 6'd0);
    base = log_wb.size();
    p0   = ret_pulses;
    run   = 1'b1;
    reset = 1'b1;
    k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("a_first_req", imem_req, 1);
    n = 0;
    while (!halted && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("a_halted", halted, 1);
    check("a_cycles", n, 15);
    check("a_retire_count", retire_count, 4);
    check("a_pulses", ret_pulses - p0, 4);
    check("a_pc", pc, 3);
    check("a_add_wb", log_wb[base+2], 16'd2);
    check("a_add_ovf", log_ovf[base+2], 0);
    check("a_addi_neg_wb", log_wb[base+1], 16'hFFFD);
    repeat (3) @(negedge clk);
    check("a_halt_pc_hold", pc, 3);

    // ---- overflow: double 1 up to 0x8000, then 0x7FFF+1 ----
    hold_reset();
    clear_imem();
    imem[0] = enc(4'd4, 3'd2, 3'd0, 6'd1);
    imem[1] = enc(4'd4, 3'd3, 3'd0, 6'd1);
    for (int i = 2; i <= 16; i++) imem[i] = enc(4'd0, 3'd3, 3'd3, {3'd3, 3'd0});
    imem[17] = enc(4'd1, 3'd4, 3'd3, {3'd2, 3'd0});   // SUB r4,r3,r2
    imem[18] = enc(4'd4, 3'd6, 3'd0, 6'd1);           // ADDI r6,r0,1
    imem[19] = enc(4'd0, 3'd1, 3'd4, {3'd2, 3'd0});   // ADD r1,r4,r2
    imem[20] = enc(4'd8, 3'd5, 3'd1, {3'd2, 3'd0});   // SLT r5,r1,r2
    imem[21] = enc(4'd4, 3'd7, 3'd0, 6'd2);           // ADDI r7,r0,2
    imem[22] = enc(4'd15, 3'd0, 3'd0, 6'd0);
    base = log_wb.size();
    run   = 1'b1;
    reset = 1'b1;
    wait_halt("b_halt_timeout", 400);
    @(negedge clk);
    check("b_log_size", log_wb.size() - base, 23);
    if (log_wb.size() - base == 23) begin
      check("b_dbl_4000", log_wb[base+15], 16'h4000);
      check("b_dbl_4000_ovf", log_ovf[base+15], 0);
      check("b_dbl_8000", log_wb[base+16], 16'h8000);
      check("b_dbl_8000_ovf", log_ovf[base+16], 1);
      check("b_sub_7fff", log_wb[base+17], 16'h7FFF);
      check("b_sub_ovf", log_ovf[base+17], 1);
      check("b_addi_ovf_clr", log_ovf[base+18], 0);
      check("b_add_8000", log_wb[base+19], 16'h8000);
      check("b_add_ovf", log_ovf[base+19], 1);
      check("b_slt_wb", log_wb[base+20], 16'd1);
      check("b_slt_keeps_ovf", log_ovf[base+20], 1);
      check("b_addi_wb", log_wb[base+21], 16'd2);
      check("b_addi_ovf", log_ovf[base+21], 0);
    end
    check("b_retire_count", retire_count, 23);

    // ---- SW/LW with two wait cycles per access ----
    hold_reset();
    load_mem_prog();
    dwait = 2;
    base  = log_wb.size();
    abase = acc_len.size();
    k     = n_unstable;
    run   = 1'b1;
    reset = 1'b1;
    wait_halt("c_halt_timeout", 300);
    @(negedge clk);
    check("c_dmem0", dmem[0], 16'hFFF9);
    check("c_dmem1_r4", dmem[1], 16'hFFF9);
    check("c_log_size", log_wb.size() - base, 6);
    check("c_acc_count", acc_len.size() - abase, 3);
    if (log_wb.size() - base == 6 && acc_len.size() - abase == 3) begin
      check("c_lw_wb", log_wb[base+2], 16'hFFF9);
      check("c_sw_latency", ret_cyc[base+1] - ret_cyc[base], 6);
      check("c_lw_latency", ret_cyc[base+2] - ret_cyc[base+1], 7);
      check("c_acc0_len", acc_len[abase], 3);
      check("c_acc1_len", acc_len[abase+1], 3);
      check("c_acc2_len", acc_len[abase+2], 3);
      check("c_beq_not_taken", log_tb[base+4], 0);
      check("c_beq_pc", log_pc[base+4], 5);
    end
    check("c_req_stable", n_unstable - k, 0);
    check("c_retire_count", retire_count, 6);

    // ---- BEQ r0,r0,-1 loops on pc 0 ----
    hold_reset();
    clear_imem();
    dwait = 0;
    imem[0] = enc(4'd7, 3'd0, 3'd0, 6'h3F);
    base  = log_wb.size();
    run   = 1'b1;
    reset = 1'b1;
    repeat (40) @(negedge clk);
    run = 1'b0;
    repeat (6) @(negedge clk);
    n = log_pc.size() - base;
    check("d1_enough_retires", (n >= 8), 1);
    if (n >= 8) begin
      check("d1_pc", log_pc[base+n-1], 0);
      check("d1_taken", log_tb[base+n-1], 1);
      check("d1_period", ret_cyc[base+n-1] - ret_cyc[base+n-2], 3);
    end
    check("d1_idle_no_req", imem_req, 0);
    check("d1_count", retire_count, n);

    // ---- pc wrap: BEQ -2 from 0 lands on 511, BEQ +0 at 511 wraps to 0 ----
    hold_reset();
    clear_imem();
    imem[0]   = enc(4'd7, 3'd0, 3'd0, 6'h3E);
    imem[511] = enc(4'd7, 3'd0, 3'd0, 6'd0);
    base  = log_pc.size();
    run   = 1'b1;
    reset = 1'b1;
    k = 0;
    while (log_pc.size() - base < 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    run = 1'b0;
    check("d2_retires", (log_pc.size() - base >= 3), 1);
    if (log_pc.size() - base >= 3) begin
      check("d2_pc_511", log_pc[base], 9'd511);
      check("d2_pc_wrap0", log_pc[base+1], 9'd0);
      check("d2_pc_511b", log_pc[base+2], 9'd511);
      check("d2_taken", log_tb[base+1], 1);
    end
    repeat (6) @(negedge clk);

    // ---- step control ----
    hold_reset();
    clear_imem();
    imem[0] = enc(4'd4, 3'd1, 3'd0, 6'd9);
    imem[1] = enc(4'd4, 3'd2, 3'd0, 6'd4);
    imem[2] = enc(4'd15, 3'd0, 3'd0, 6'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("e_idle_no_req", imem_req, 0);
    p0   = ret_pulses;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (12) @(negedge clk);
    check("e1_count", retire_count, 1);
    check("e1_pulses", ret_pulses - p0, 1);
    check("e1_pc", pc, 1);
    check("e1_wb", wb_data, 16'd9);
    check("e1_idle", imem_req, 0);
    step = 1'b1;
    repeat (25) @(negedge clk);
    check("e2_held_count", retire_count, 2);
    check("e2_wb", wb_data, 16'd4);
    check("e2_pc", pc, 2);
    step = 1'b0;
    repeat (3) @(negedge clk);
    check("e2_still_idle", retire_count, 2);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_halt("e3_halt_timeout", 30);
    check("e3_count", retire_count, 3);
    check("e3_pulses", ret_pulses - p0, 3);

    // ---- reset asserted mid-MEM ----
    hold_reset();
    load_mem_prog();
    dwait = 5;
    run   = 1'b1;
    reset = 1'b1;
    k = 0;
    while (!dmem_req && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("f_in_mem", dmem_req, 1);
    check("f_pre_pc", pc, 1);
    check("f_pre_count", retire_count, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("f_async_dmem_req", dmem_req, 0);
    check("f_async_pc", pc, 0);
    check("f_async_count", retire_count, 0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("f_idle_imem_req", imem_req, 0);
    check("f_idle_dmem_req", dmem_req, 0);
    check("f_idle_pc", pc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
